// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the multi-read-port register file.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   reg_addr_t / reg_data_t : register address and data types at the defaults
//   ZERO_ADDR               : address of the hardwired zero register
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    localparam reg_addr_t ZERO_ADDR = '0;

endpackage : regfile_pkg

// File: rtl/regfile_mp_busy_table.sv
// -----------------------------------------------------------------------------
// rf_busy_table
// Per-register scoreboard. A reservation sets a bit, a writeback clears it;
// when both hit the same register in one cycle the reservation wins.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   set_en, set_addr      : reservation request and target register
//   clr_en, clr_addr      : writeback release and target register
//   set_ok                : reservation would be accepted this cycle
//   busy_vec              : full busy table, bit i = register i
// With ZERO_REG != 0, register 0 always accepts a reservation but never
// becomes busy.
// -----------------------------------------------------------------------------
module rf_busy_table
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [ADDR_W-1:0]    set_addr,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_addr,
    output logic                 set_ok,
    output logic [(1<<ADDR_W)-1:0] busy_vec
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             set_is_zero;
    logic             set_take;

    assign set_is_zero = (ZERO_REG != 0) && (set_addr == ADDR_W'(ZERO_ADDR));

    // A register being released this very cycle may be re-reserved at once.
    assign set_ok   = set_is_zero || !busy_q[set_addr]
                      || (clr_en && (clr_addr == set_addr));
    assign set_take = set_en && set_ok && !set_is_zero;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        // Applied after the clear so a same-address reserve wins.
        if (set_take) begin
            busy_d[set_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule : rf_busy_table

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised register file with NUM_RD combinational read ports, one
// writeback port and a reservation scoreboard for the decode stage.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears data and busy)
//   rd_addr     : NUM_RD packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data     : NUM_RD packed read data, port p at [p*DATA_W +: DATA_W]
//   rd_busy     : per-port pending-write flag of the addressed register
//   wr_en, wr_addr, wr_data : writeback (also releases the reservation)
//   rsv_en, rsv_addr        : issue-stage reservation request
//   rsv_ok      : reservation accepted this cycle (no dependence on rsv_en)
//   busy_vec    : full busy table
// Build option: RF_BYPASS_EN enables same-cycle write-through forwarding from
// the writeback port to matching read ports.
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rsv_en,
    input  logic [ADDR_W-1:0]           rsv_addr,
    output logic                        rsv_ok,
    output logic [(1<<ADDR_W)-1:0]      busy_vec
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_take;

    // Writes to the hardwired zero register are dropped entirely.
    assign wr_take = wr_en
                     && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_ADDR)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_take) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    rf_busy_table #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (rsv_en),
        .set_addr (rsv_addr),
        .clr_en   (wr_take),
        .clr_addr (wr_addr),
        .set_ok   (rsv_ok),
        .busy_vec (busy_vec)
    );

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              ra_zero;
            logic              fwd;

            assign ra      = rd_addr[gi*ADDR_W +: ADDR_W];
            assign ra_zero = (ZERO_REG != 0) && (ra == ADDR_W'(ZERO_ADDR));
`ifdef RF_BYPASS_EN
            // rst_n gating keeps read data at zero while reset is held.
            assign fwd     = wr_take && rst_n && (wr_addr == ra);
`else
            assign fwd     = 1'b0;
`endif
            assign rd_data[gi*DATA_W +: DATA_W] = ra_zero ? '0 :
                                                  fwd     ? wr_data : mem_q[ra];
            // busy_vec[0] is already held low for the zero register.
            assign rd_busy[gi] = fwd ? 1'b0 : busy_vec[ra];
        end
    endgenerate

endmodule : regfile_mp
